// File: rtl/prio_q_sorted_pkg.sv
// Shared definitions for the sorted-register priority queue.
// Contents:
//   DW         - default total event width (key + payload)
//   DEF_KEY_W  - default sort-key width (event timestamp)
//   op_e       - operation code, encoded as {enq, deq}
package prio_q_sorted_pkg;

  localparam int DW        = 32;
  localparam int DEF_KEY_W = 16;

  // {enq, deq} decode; the queue logic works on the effective opcode after
  // the full/empty rules have been applied.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DEQ  = 2'b01,
    ENQ  = 2'b10,
    REPL = 2'b11
  } op_e;

endpackage

// File: rtl/prio_q_cell.sv
// One storage slot of the sorted priority queue.
// Ports:
//   CLK, rst_n      - clock, async active-low reset
//   i_flush         - synchronous clear of this slot
//   i_op            - effective operation (op_e encoding)
//   i_pos           - decoded insert position for this cycle
//   i_left_*        - contents of slot IDX-1 (zero for slot 0)
//   i_right_*       - contents of slot IDX+1 (zero for the last slot)
//   i_inp_*         - entry being inserted
//   o_key, o_data   - registered slot contents
//   o_le            - local compare: stored key <= incoming key
module prio_q_cell
  import prio_q_sorted_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int DATA_W = DW - DEF_KEY_W,
  parameter int CNT_W  = 6,
  parameter int IDX    = 0
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic [1:0]        i_op,
  input  logic [CNT_W-1:0]  i_pos,
  input  logic [KEY_W-1:0]  i_left_key,
  input  logic [DATA_W-1:0] i_left_data,
  input  logic [KEY_W-1:0]  i_right_key,
  input  logic [DATA_W-1:0] i_right_data,
  input  logic [KEY_W-1:0]  i_inp_key,
  input  logic [DATA_W-1:0] i_inp_data,
  output logic [KEY_W-1:0]  o_key,
  output logic [DATA_W-1:0] o_data,
  output logic              o_le
);

  localparam logic [CNT_W-1:0] MY_IDX = CNT_W'(IDX);

  logic [KEY_W-1:0]  r_key;
  logic [DATA_W-1:0] r_data;
  logic [KEY_W-1:0]  w_key_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  // Unsigned compare on key bits only; payload never takes part.
  assign o_le = (r_key <= i_inp_key);

  // Next-value mux: hold, take left neighbour (shift up on insert), take
  // right neighbour (shift down on remove) or load the incoming entry.
  // Because invalid slots always hold zero, shifting naturally keeps the
  // unused tail zeroed without any knowledge of the count here.
  always_comb begin
    w_key_nxt  = r_key;
    w_data_nxt = r_data;
    if (i_flush) begin
      w_key_nxt  = '0;
      w_data_nxt = '0;
    end else begin
      case (op_e'(i_op))
        ENQ: begin
          if (MY_IDX == i_pos) begin
            w_key_nxt  = i_inp_key;
            w_data_nxt = i_inp_data;
          end else if (MY_IDX > i_pos) begin
            w_key_nxt  = i_left_key;
            w_data_nxt = i_left_data;
          end
        end
        DEQ: begin
          w_key_nxt  = i_right_key;
          w_data_nxt = i_right_data;
        end
        REPL: begin
          // Head leaves; slots below the new entry's position close the gap.
          if (MY_IDX < i_pos) begin
            w_key_nxt  = i_right_key;
            w_data_nxt = i_right_data;
          end else if (MY_IDX == i_pos) begin
            w_key_nxt  = i_inp_key;
            w_data_nxt = i_inp_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Slot register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_data <= '0;
    end else begin
      r_key  <= w_key_nxt;
      r_data <= w_data_nxt;
    end
  end

  assign o_key  = r_key;
  assign o_data = r_data;

endmodule

// File: rtl/prio_q_sorted.sv
// Sorted-register priority queue: DEPTH slots kept in ascending key order,
// minimum-key entry always at the head. Equal keys leave in arrival order.
// Ports:
//   CLK, rst_n           - clock, async active-low reset
//   flush                - synchronous clear (overrides enq/deq)
//   enq, inp_key/data    - insert request and entry
//   deq                  - remove head; enq+deq together is a replace
//   out_key/data/valid   - head entry
//   full, empty, count   - occupancy
//   ovf_err, udf_err     - one-cycle error pulses
module prio_q_sorted
  import prio_q_sorted_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int DATA_W = DW - 16,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              enq,
  input  logic              deq,
  input  logic [KEY_W-1:0]  inp_key,
  input  logic [DATA_W-1:0] inp_data,
  output logic [KEY_W-1:0]  out_key,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_err,
  output logic              udf_err
);

  logic [KEY_W-1:0]  w_key  [DEPTH];
  logic [DATA_W-1:0] w_data [DEPTH];
  logic [DEPTH-1:0]  w_le;
  logic [DEPTH-1:0]  w_le_v;
  logic [CNT_W-1:0]  w_p;
  logic [CNT_W-1:0]  w_pp;
  logic [CNT_W-1:0]  w_pos;
  logic [CNT_W-1:0]  w_count_nxt;
  op_e               w_op;
  logic              w_ovf;
  logic              w_udf;

  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_udf;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [KEY_W-1:0]  w_left_key;
    logic [DATA_W-1:0] w_left_data;
    logic [KEY_W-1:0]  w_right_key;
    logic [DATA_W-1:0] w_right_data;

    if (g == 0) begin : g_first
      assign w_left_key  = '0;
      assign w_left_data = '0;
    end else begin : g_inner_l
      assign w_left_key  = w_key[g-1];
      assign w_left_data = w_data[g-1];
    end

    if (g == DEPTH - 1) begin : g_last
      assign w_right_key  = '0;
      assign w_right_data = '0;
    end else begin : g_inner_r
      assign w_right_key  = w_key[g+1];
      assign w_right_data = w_data[g+1];
    end

    // Invalid slots hold zero and would always compare true; mask them.
    assign w_le_v[g] = w_le[g] && (CNT_W'(g) < r_count);

    prio_q_cell #(
      .KEY_W (KEY_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W),
      .IDX   (g)
    ) u_cell (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .i_flush     (flush),
      .i_op        (w_op),
      .i_pos       (w_pos),
      .i_left_key  (w_left_key),
      .i_left_data (w_left_data),
      .i_right_key (w_right_key),
      .i_right_data(w_right_data),
      .i_inp_key   (inp_key),
      .i_inp_data  (inp_data),
      .o_key       (w_key[g]),
      .o_data      (w_data[g]),
      .o_le        (w_le[g])
    );
  end

  // Insert positions: p counts all valid slots with key <= inp_key, p'
  // skips the head because a replace removes it first.
  always_comb begin
    w_p  = '0;
    w_pp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_p = w_p + CNT_W'(w_le_v[i]);
      if (i >= 1) begin
        w_pp = w_pp + CNT_W'(w_le_v[i]);
      end
    end
  end

  // Operation decode: applies the full/empty rules to produce the
  // effective opcode, next count and error pulses. A replace on an empty
  // queue degrades to a plain insert at slot 0.
  always_comb begin
    w_op        = IDLE;
    w_pos       = w_p;
    w_count_nxt = r_count;
    w_ovf       = 1'b0;
    w_udf       = 1'b0;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case (op_e'({enq, deq}))
        ENQ: begin
          if (r_full) begin
            w_ovf = 1'b1;
          end else begin
            w_op        = ENQ;
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        DEQ: begin
          if (r_empty) begin
            w_udf = 1'b1;
          end else begin
            w_op        = DEQ;
            w_count_nxt = r_count - CNT_W'(1);
          end
        end
        REPL: begin
          if (r_empty) begin
            w_udf       = 1'b1;
            w_op        = ENQ;
            w_count_nxt = CNT_W'(1);
          end else begin
            w_op  = REPL;
            w_pos = w_pp;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Occupancy flags are registered from the next count so every output
  // comes straight from a flop.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_ovf   <= w_ovf;
      r_udf   <= w_udf;
    end
  end

  assign out_key   = w_key[0];
  assign out_data  = w_data[0];
  assign out_valid = r_valid;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign ovf_err   = r_ovf;
  assign udf_err   = r_udf;

endmodule

// File: tb/tb_prio_q_sorted.sv
// Testbench for prio_q_sorted. Two instances (DEPTH=8 and DEPTH=4) share
// the same stimulus; a list-based reference model per instance predicts
// the head and flags, and directed checks pin specific values.
module tb_prio_q_sorted;

  typedef struct packed {
    logic [15:0] k;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        enq;
  logic        deq;
  logic [15:0] inKey;
  logic [15:0] inData;

  logic [15:0] key8, data8, key4, data4;
  logic        valid8, full8, empty8, ovf8, udf8;
  logic        valid4, full4, empty4, ovf4, udf4;
  logic [3:0]  count8;
  logic [2:0]  count4;

  int total = 0;
  int bad   = 0;

  ent_t mq [2][8];
  int   mc [2];
  logic mOvf [2];
  logic mUdf [2];

  prio_q_sorted #(.KEY_W(16), .DATA_W(16), .DEPTH(8)) u_dut8 (
    .CLK(clk), .rst_n(rst_n), .flush(flush), .enq(enq), .deq(deq),
    .inp_key(inKey), .inp_data(inData),
    .out_key(key8), .out_data(data8), .out_valid(valid8),
    .full(full8), .empty(empty8), .count(count8),
    .ovf_err(ovf8), .udf_err(udf8)
  );

  prio_q_sorted #(.KEY_W(16), .DATA_W(16), .DEPTH(4)) u_dut4 (
    .CLK(clk), .rst_n(rst_n), .flush(flush), .enq(enq), .deq(deq),
    .inp_key(inKey), .inp_data(inData),
    .out_key(key4), .out_data(data4), .out_valid(valid4),
    .full(full4), .empty(empty4), .count(count4),
    .ovf_err(ovf4), .udf_err(udf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depthOf(int idx);
    return (idx == 0) ? 8 : 4;
  endfunction

  function automatic void checkVal(string name, int idx, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s (inst %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    checkVal(name, -1, act, exp);
  endtask

  // Reference model: an ordered list; insert after all keys <= new key.
  task automatic modelInsert(int idx, logic [15:0] k, logic [15:0] d);
    int p = 0;
    for (int i = 0; i < mc[idx]; i++) begin
      if (mq[idx][i].k <= k) p++;
    end
    for (int i = mc[idx]; i > p; i--) begin
      mq[idx][i] = mq[idx][i-1];
    end
    mq[idx][p] = '{k: k, d: d};
    mc[idx]++;
  endtask

  task automatic modelPop(int idx);
    for (int i = 0; i < mc[idx] - 1; i++) begin
      mq[idx][i] = mq[idx][i+1];
    end
    mc[idx]--;
  endtask

  task automatic modelClear();
    for (int n = 0; n < 2; n++) begin
      mc[n]   = 0;
      mOvf[n] = 1'b0;
      mUdf[n] = 1'b0;
    end
  endtask

  task automatic modelStep(int idx);
    mOvf[idx] = 1'b0;
    mUdf[idx] = 1'b0;
    if (flush) begin
      mc[idx] = 0;
    end else if (enq && !deq) begin
      if (mc[idx] == depthOf(idx)) mOvf[idx] = 1'b1;
      else modelInsert(idx, inKey, inData);
    end else if (!enq && deq) begin
      if (mc[idx] == 0) mUdf[idx] = 1'b1;
      else modelPop(idx);
    end else if (enq && deq) begin
      if (mc[idx] == 0) mUdf[idx] = 1'b1;
      else modelPop(idx);
      modelInsert(idx, inKey, inData);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelClear();
    end else begin
      modelStep(0);
      modelStep(1);
    end
  end

  task automatic compareInst(int idx, logic [15:0] k, logic [15:0] d, logic v,
                             logic f, logic e, int c, logic ov, logic ud);
    int ek = (mc[idx] > 0) ? int'(mq[idx][0].k) : 0;
    int ed = (mc[idx] > 0) ? int'(mq[idx][0].d) : 0;
    checkVal("out_key",   idx, k,  ek);
    checkVal("out_data",  idx, d,  ed);
    checkVal("out_valid", idx, v,  int'(mc[idx] > 0));
    checkVal("full",      idx, f,  int'(mc[idx] == depthOf(idx)));
    checkVal("empty",     idx, e,  int'(mc[idx] == 0));
    checkVal("count",     idx, c,  mc[idx]);
    checkVal("ovf_err",   idx, ov, int'(mOvf[idx]));
    checkVal("udf_err",   idx, ud, int'(mUdf[idx]));
  endtask

  // Every settled cycle out of reset, both instances follow the model.
  always @(negedge clk) begin
    if (rst_n) begin
      compareInst(0, key8, data8, valid8, full8, empty8, int'(count8), ovf8, udf8);
      compareInst(1, key4, data4, valid4, full4, empty4, int'(count4), ovf4, udf4);
    end
  end

  // Called at a negedge: drive one operation, return at the next negedge
  // with its result visible and inputs back to idle.
  task automatic applyStimulus(logic e, logic dq, logic f, logic [15:0] k, logic [15:0] dat);
    enq    = e;
    deq    = dq;
    flush  = f;
    inKey  = k;
    inData = dat;
    @(negedge clk);
    enq   = 1'b0;
    deq   = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    modelClear();
    rst_n  = 1'b1;
    flush  = 1'b0;
    enq    = 1'b0;
    deq    = 1'b0;
    inKey  = '0;
    inData = '0;
    #2 rst_n = 1'b0;
    #10;
    checkOutput("rst_valid8", valid8, 0);
    checkOutput("rst_empty8", empty8, 1);
    checkOutput("rst_full4",  full4,  0);
    checkOutput("rst_count8", count8, 0);
    checkOutput("rst_key4",   key4,   0);
    checkOutput("rst_ovf8",   ovf8,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ties: B before D.
    applyStimulus(1, 0, 0, 16'd5, 16'hA);
    applyStimulus(1, 0, 0, 16'd3, 16'hB);
    applyStimulus(1, 0, 0, 16'd9, 16'hC);
    applyStimulus(1, 0, 0, 16'd3, 16'hD);
    checkOutput("tie_key8",   key8,   3);
    checkOutput("tie_data8",  data8,  16'hB);
    checkOutput("tie_count8", count8, 4);
    checkOutput("tie_full4",  full4,  1);

    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("deq1_key8",  key8,  3);
    checkOutput("deq1_data8", data8, 16'hD);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("deq2_key8",  key8,  5);
    checkOutput("deq2_data8", data8, 16'hA);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("deq3_key8",  key8,  9);
    checkOutput("deq3_data8", data8, 16'hC);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("deq4_valid8", valid8, 0);
    checkOutput("deq4_empty8", empty8, 1);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("udf_pulse8", udf8,   1);
    checkOutput("udf_count8", count8, 0);
    checkOutput("udf_pulse4", udf4,   1);
    applyStimulus(0, 0, 0, 16'd0, 16'h0);
    checkOutput("udf_clear8", udf8, 0);

    // Fill DEPTH=4, overflow, then replace while full.
    applyStimulus(1, 0, 0, 16'd10, 16'h1);
    applyStimulus(1, 0, 0, 16'd20, 16'h2);
    applyStimulus(1, 0, 0, 16'd30, 16'h3);
    applyStimulus(1, 0, 0, 16'd40, 16'h4);
    applyStimulus(1, 0, 0, 16'd15, 16'h5);
    checkOutput("ovf_pulse4", ovf4,   1);
    checkOutput("ovf_key4",   key4,   10);
    checkOutput("ovf_count4", count4, 4);
    checkOutput("ovf_full4",  full4,  1);
    checkOutput("ovf_none8",  ovf8,   0);
    checkOutput("ovf_count8", count8, 5);
    applyStimulus(1, 1, 0, 16'd25, 16'h6);
    checkOutput("repl_key4",   key4,   20);
    checkOutput("repl_full4",  full4,  1);
    checkOutput("repl_ovf4",   ovf4,   0);
    checkOutput("repl_udf4",   udf4,   0);
    checkOutput("repl_key8",   key8,   15);
    checkOutput("repl_count8", count8, 5);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("drain1_key4", key4, 25);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("drain2_key4", key4, 30);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("drain3_key4", key4, 40);
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    checkOutput("drain4_empty4", empty4, 1);
    checkOutput("drain4_key8",   key8,   40);
    checkOutput("drain4_count8", count8, 1);

    // Replace at the extremes.
    applyStimulus(0, 0, 1, 16'd0, 16'h0);
    checkOutput("flush_count8", count8, 0);
    applyStimulus(1, 0, 0, 16'd10, 16'h7);
    applyStimulus(1, 0, 0, 16'd20, 16'h8);
    applyStimulus(1, 0, 0, 16'd30, 16'h9);
    applyStimulus(1, 1, 0, 16'd1, 16'h10);
    checkOutput("rmin_key8",   key8,   1);
    checkOutput("rmin_count8", count8, 3);
    applyStimulus(1, 1, 0, 16'd50, 16'h11);
    checkOutput("rmax_key8",  key8,  20);
    checkOutput("rmax_data4", data4, 16'h8);

    // Flush wins over enq.
    applyStimulus(1, 0, 1, 16'd99, 16'h99);
    checkOutput("fe_count8", count8, 0);
    checkOutput("fe_empty4", empty4, 1);
    checkOutput("fe_ovf8",   ovf8,   0);
    checkOutput("fe_udf8",   udf8,   0);
    applyStimulus(1, 0, 0, 16'd7, 16'h12);
    checkOutput("fe_next_key8",   key8,   7);
    checkOutput("fe_next_count8", count8, 1);

    // Async reset between edges.
    applyStimulus(1, 0, 0, 16'd8,  16'h13);
    applyStimulus(1, 0, 0, 16'd6,  16'h14);
    applyStimulus(1, 0, 0, 16'd12, 16'h15);
    applyStimulus(1, 0, 0, 16'd1,  16'h16);
    checkOutput("pre_rst_count8", count8, 5);
    checkOutput("pre_rst_key8",   key8,   1);
    checkOutput("pre_rst_key4",   key4,   6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_count8", count8, 0);
    checkOutput("arst_key8",   key8,   0);
    checkOutput("arst_valid8", valid8, 0);
    checkOutput("arst_empty8", empty8, 1);
    checkOutput("arst_full4",  full4,  0);
    checkOutput("arst_data4",  data4,  0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 16'd2, 16'h17);
    checkOutput("post_rst_count8", count8, 1);
    checkOutput("post_rst_key8",   key8,   2);

    // Replace on empty acts as enq with udf; replace with equal key.
    applyStimulus(0, 1, 0, 16'd0, 16'h0);
    applyStimulus(1, 1, 0, 16'd42, 16'h42);
    checkOutput("re_udf8",   udf8,   1);
    checkOutput("re_count8", count8, 1);
    checkOutput("re_key8",   key8,   42);
    applyStimulus(1, 1, 0, 16'd42, 16'h43);
    checkOutput("req_data8",  data8,  16'h43);
    checkOutput("req_count4", count4, 1);
    checkOutput("req_udf8",   udf8,   0);

    applyStimulus(0, 0, 0, 16'd0, 16'h0);
    applyStimulus(0, 0, 0, 16'd0, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
